// File: rtl/bdc_uart_pkg.sv
// Shared constants for the framed UART transmit path: header bytes,
// frame FSM state encoding and the 10-bit serial character builder.
package bdc_uart_pkg;

    localparam logic [7:0] FRAME_HDR0 = 8'h55;
    localparam logic [7:0] FRAME_HDR1 = 8'hAA;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR0    = 3'd1;
    localparam logic [2:0] ST_HDR1    = 3'd2;
    localparam logic [2:0] ST_LEN     = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_CSUM    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_HDR0    = ST_HDR0,
        S_HDR1    = ST_HDR1,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CSUM    = ST_CSUM
    } tx_state_t;

    // Serial character as shifted out LSB first: start(0), data, stop(1).
    function automatic logic [9:0] uart_char(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and a
// registered full flag that reflects this cycle's push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push  = wr_en & ~r_full;
    assign w_pop   = rd_en & (r_count != '0);
    assign rd_data = r_mem[r_rptr];
    assign count   = r_count;
    assign full    = r_full;
    assign empty   = (r_count == '0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= wr_data;
    end

    // Pointers, occupancy and full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: buffers payload bytes and on send emits
// 0x55, 0xAA, LEN, payload..., CSUM as back-to-back 8N1 characters.
module uart_frame_tx
    import bdc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    localparam int BW          = $clog2(CLKS_PER_BIT),
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    input  logic       send,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    tx_state_t     r_state, w_state_n;
    logic [9:0]    r_shift, w_shift_n;
    logic [3:0]    r_bit,   w_bit_n;
    logic [BW-1:0] r_baud,  w_baud_n;
    logic [CW-1:0] r_remain, w_remain_n;
    logic [7:0]    r_csum,  w_csum_n;
    logic [7:0]    r_len,   w_len_n;
    logic          r_done,  w_done_n;
    logic          w_pop;
    logic [7:0]    w_rd_data;
    logic [CW-1:0] w_count;
    logic          w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count),
        .full    (full),
        .empty   (w_empty)
    );

    // Idle shifter holds all ones, so its LSB doubles as the idle-high line.
    assign txd  = r_shift[0];
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    // Frame sequencing, bit timing and character loading.
    always_comb begin
        w_state_n  = r_state;
        w_shift_n  = r_shift;
        w_bit_n    = r_bit;
        w_baud_n   = r_baud;
        w_remain_n = r_remain;
        w_csum_n   = r_csum;
        w_len_n    = r_len;
        w_done_n   = 1'b0;
        w_pop      = 1'b0;
        if (r_state == S_IDLE) begin
            // LEN is the pre-write count; a same-cycle write joins the next frame.
            if (send) begin
                w_state_n  = S_HDR0;
                w_shift_n  = uart_char(FRAME_HDR0);
                w_bit_n    = '0;
                w_baud_n   = '0;
                w_remain_n = w_count;
                w_len_n    = 8'(w_count);
                w_csum_n   = 8'(w_count);
            end
        end else if (r_baud != BW'(CLKS_PER_BIT - 1)) begin
            w_baud_n = r_baud + 1'b1;
        end else begin
            w_baud_n = '0;
            if (r_bit != 4'd9) begin
                w_shift_n = {1'b1, r_shift[9:1]};
                w_bit_n   = r_bit + 1'b1;
            end else begin
                // Character finished: load the next one with no idle gap.
                w_bit_n = '0;
                case (r_state)
                    S_HDR0: begin
                        w_state_n = S_HDR1;
                        w_shift_n = uart_char(FRAME_HDR1);
                    end
                    S_HDR1: begin
                        w_state_n = S_LEN;
                        w_shift_n = uart_char(r_len);
                    end
                    S_LEN, S_PAYLOAD: begin
                        if (r_remain == '0 || w_empty) begin
                            w_state_n = S_CSUM;
                            w_shift_n = uart_char(r_csum);
                        end else begin
                            w_state_n  = S_PAYLOAD;
                            w_shift_n  = uart_char(w_rd_data);
                            w_pop      = 1'b1;
                            w_remain_n = r_remain - 1'b1;
                            w_csum_n   = r_csum + w_rd_data;
                        end
                    end
                    default: begin
                        w_state_n = S_IDLE;
                        w_shift_n = '1;
                        w_done_n  = 1'b1;
                    end
                endcase
            end
        end
    end

    // State register; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '1;
            r_bit    <= '0;
            r_baud   <= '0;
            r_remain <= '0;
            r_csum   <= '0;
            r_len    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_shift  <= w_shift_n;
            r_bit    <= w_bit_n;
            r_baud   <= w_baud_n;
            r_remain <= w_remain_n;
            r_csum   <= w_csum_n;
            r_len    <= w_len_n;
            r_done   <= w_done_n;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: txd decoded by a bit-accurate monitor, frames
// predicted from a byte-queue model of the payload buffer.
module tb_uart_frame_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       send;
    logic       txd;
    logic       busy;
    logic       done;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         mon_ferr = 0;
    logic [7:0] mon_b;
    logic [7:0] rx_q[$];
    logic [7:0] fifo_m[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .send    (send),
        .txd     (txd),
        .busy    (busy),
        .done    (done)
    );

    // Serial monitor: sample each bit in its middle, collect bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && reset === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) mon_ferr++;
                rx_q.push_back(mon_b);
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] d);
        if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
    endfunction

    // Expected frame: headers, LEN, LEN oldest bytes, (LEN + sum) mod 256.
    function automatic void build_exp();
        int len;
        int sum;
        logic [7:0] b;
        exp_q.delete();
        len = fifo_m.size();
        sum = len;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = fifo_m.pop_front();
            exp_q.push_back(b);
            sum += b;
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_push(d);
    endtask

    // Send one frame and check timing, busy span, done pulse and bytes.
    task automatic run_frame(input string tag, input bit mid_send, input bit with_wr,
                             input logic [7:0] wd);
        int nb;
        int limit;
        int k;
        int busy_n;
        int done_k;
        logic [31:0] obs;
        build_exp();
        rx_q.delete();
        send = 1'b1;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_data = wd;
        end
        @(posedge clk);
        #1;
        send  = 1'b0;
        wr_en = 1'b0;
        if (with_wr) model_push(wd);
        nb     = exp_q.size();
        limit  = 10 * CPB * nb;
        k      = 0;
        busy_n = 0;
        done_k = 0;
        while (done_k == 0 && k < limit + 20) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, " start bit"}, {31'd0, txd}, 32'd0);
            if (mid_send && k == limit / 2) send = 1'b1;
            if (mid_send && k == limit / 2 + 1) send = 1'b0;
            if (busy) busy_n++;
            if (done) done_k = k;
        end
        chk({tag, " done cycle"}, done_k, limit + 1);
        chk({tag, " busy cycles"}, busy_n, limit);
        chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, " done one-shot"}, {31'd0, done}, 32'd0);
        chk({tag, " byte count"}, rx_q.size(), nb);
        for (int i = 0; i < nb; i++) begin
            obs = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 'x;
            chk($sformatf("%s byte%0d", tag, i), obs, {24'd0, exp_q[i]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dn;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        send    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset txd", {31'd0, txd}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset full", {31'd0, full}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single byte payload
        wr(8'h31);
        run_frame("t1", 1'b0, 1'b0, 8'h00);

        // 2: empty frame, then line stays idle
        run_frame("t2", 1'b0, 1'b0, 8'h00);
        repeat (20) @(negedge clk);
        chk("t2 idle txd", {31'd0, txd}, 32'd1);
        chk("t2 idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // 3: overfill, the 17th byte is dropped
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(8'($urandom));
            if (i >= DEPTH - 2)
                chk($sformatf("t3 full after %0d", i + 1), {31'd0, full},
                    {31'd0, fifo_m.size() == DEPTH});
        end
        run_frame("t3", 1'b0, 1'b0, 8'h00);
        chk("t3 full after frame", {31'd0, full}, 32'd0);

        // 4: checksum wrap to zero, send during frame ignored
        wr(8'hFF);
        wr(8'hFF);
        run_frame("t4", 1'b1, 1'b0, 8'h00);
        rx_q.delete();
        repeat (60) @(negedge clk);
        chk("t4 no second frame", rx_q.size(), 0);
        chk("t4 idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // 5: same-cycle write goes to the next frame
        wr(8'h10);
        run_frame("t5a", 1'b0, 1'b1, 8'h20);
        run_frame("t5b", 1'b0, 1'b0, 8'h00);

        // 6: reset while in payload
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
        chk("t6 full before send", {31'd0, full}, 32'd1);
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        repeat (10 * CPB * 3 + 10) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 reset txd", {31'd0, txd}, 32'd1);
        chk("t6 reset busy", {31'd0, busy}, 32'd0);
        chk("t6 reset full", {31'd0, full}, 32'd0);
        chk("t6 reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        fifo_m.delete();
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t6 no done after abort", dn, 0);
        @(posedge clk);
        #1;
        wr(8'($urandom));
        wr(8'($urandom));
        run_frame("t6 post", 1'b0, 1'b0, 8'h00);

        // random payload lengths
        for (int f = 0; f < 3; f++) begin
            int n;
            n = int'($urandom_range(0, DEPTH));
            for (int i = 0; i < n; i++) wr(8'($urandom));
            run_frame($sformatf("rnd%0d", f), 1'b0, 1'b0, 8'h00);
        end

        chk("stop bits", mon_ferr, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
